// File: rtl/coef_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : coef_stream_reader
// Purpose  : Walks a contiguous address range of a registered-read coefficient
//            RAM and presents the words as a valid/ready stream with a
//            last-beat marker. A 2-entry buffer absorbs the one-cycle read
//            latency so backpressure never loses or duplicates a word.
// Revision : 1.0 - initial release
// ============================================================================
module coef_stream_reader #(
    parameter int MEM_WIDTH = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = $clog2(MEM_DEPTH) + 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [$clog2(MEM_DEPTH)-1:0] base_addr,
    input  logic [CNT_W-1:0]             count,
    output logic                         busy,
    output logic                         done,
    output logic                         ram_enable,
    output logic                         ram_write_en,
    output logic                         ram_reset,
    output logic [$clog2(MEM_DEPTH)-1:0] ram_address,
    input  logic [MEM_WIDTH-1:0]         ram_data_out,
    output logic [MEM_WIDTH-1:0]         m_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic                         m_last
);

    localparam int            AW          = $clog2(MEM_DEPTH);
    localparam logic [AW-1:0] c_LAST_ADDR = AW'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [AW-1:0]        r_addr;
    logic [CNT_W-1:0]     r_remaining;
    logic                 r_inflight;
    logic                 r_inflight_last;
    logic                 r_done;

    logic [MEM_WIDTH-1:0] r_fifo_data [2];
    logic [1:0]           r_fifo_last;
    logic                 r_rd_ptr;
    logic                 r_wr_ptr;
    logic [1:0]           r_fifo_count;

    logic                 w_valid;
    logic                 w_pop;
    logic                 w_push;
    logic                 w_issue;
    logic                 w_cmd_done;
    logic                 w_final_issue;
    logic [2:0]           w_occupancy;

    assign w_valid       = (r_fifo_count != 2'd0);
    assign w_pop         = w_valid & m_ready;
    assign w_push        = r_inflight;
    assign w_final_issue = (r_remaining == CNT_W'(1));
    // Slots that will be taken after this edge if no new read is issued.
    assign w_occupancy   = {1'b0, r_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, read-issue decision and command-completion detection.
    always_comb begin
        w_state_next = r_state;
        w_issue      = 1'b0;
        w_cmd_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = (count == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if ((r_remaining != '0) && (w_occupancy < 3'd2)) begin
                    w_issue = 1'b1;
                    if (w_final_issue) begin
                        w_state_next = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Finish on the edge that accepts the final buffered beat.
                if (!r_inflight && (r_fifo_count == {1'b0, w_pop})) begin
                    w_state_next = S_IDLE;
                    w_cmd_done   = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Command address and remaining-word bookkeeping; address wraps explicitly.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_addr      <= '0;
            r_remaining <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_addr      <= base_addr;
            r_remaining <= count;
        end else if (w_issue) begin
            r_addr      <= (r_addr == c_LAST_ADDR) ? '0 : r_addr + AW'(1);
            r_remaining <= r_remaining - CNT_W'(1);
        end
    end

    // Track the read in flight through the RAM pipeline and the done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue & w_final_issue;
            r_done          <= w_cmd_done;
        end
    end

    // Output buffer pointers and occupancy; push and pop may share an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rd_ptr     <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_fifo_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fifo_count <= r_fifo_count + 2'd1;
                2'b01:   r_fifo_count <= r_fifo_count - 2'd1;
                default: r_fifo_count <= r_fifo_count;
            endcase
        end
    end

    // Output buffer storage; contents are masked at the outputs when empty.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= ram_data_out;
            r_fifo_last[r_wr_ptr] <= r_inflight_last;
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign ram_enable   = w_issue;
    assign ram_write_en = 1'b0;
    assign ram_reset    = reset;
    assign ram_address  = r_addr;
    assign m_valid      = w_valid;
    assign m_data       = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign m_last       = w_valid & r_fifo_last[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_coef_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_coef_stream_reader
// Purpose  : Self-checking bench for coef_stream_reader with a registered-read
//            RAM model and a queue-based reference of the expected stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coef_stream_reader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CW    = 5;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] count = '0;
    logic          busy, done, ram_enable, ram_write_en, ram_reset;
    logic [AW-1:0] ram_address;
    logic [31:0]   ram_data_out = '0;
    logic [31:0]   m_data;
    logic          m_valid, m_last;
    logic          m_ready = 1'b0;

    coef_stream_reader #(.MEM_WIDTH(32), .MEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .start(start), .base_addr(base_addr),
        .count(count), .busy(busy), .done(done), .ram_enable(ram_enable),
        .ram_write_en(ram_write_en), .ram_reset(ram_reset),
        .ram_address(ram_address), .ram_data_out(ram_data_out),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    always #5 clock = ~clock;

    // Coefficient RAM: registered read with one-cycle latency.
    logic [31:0] mem [DEPTH];
    always @(posedge clock) begin
        if (ram_enable) ram_data_out <= mem[ram_address];
    end

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        int          base;
        int          cnt;
        int          mode;      // 0 ready=1, 1 random, 2 stall 3..8 then toggle, 3 mostly stalled
        bit          poke;      // pulse start while busy
        int          exp_done;  // expected done cycle (0 = not fixed)
        logic [31:0] exp_last;  // expected data of the final beat
    } vec_t;

    int    checks = 0;
    int    failures = 0;
    beat_t exp_q [$];
    int    cyc, cur_cnt, exp_addr, issued, accepted, last_acc_cyc;
    bit    done_seen, stall_prev;
    logic [31:0] prev_data, last_word;
    logic        prev_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic ready_fn(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom % 2);
            2:       return (c >= 3 && c <= 8) ? 1'b0 : ((c % 2) == 1);
            default: return (($urandom % 4) == 0);
        endcase
    endfunction

    task automatic init_model(input int base, input int cnt);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < cnt; i++) begin
            b.data = mem[(base + i) % DEPTH];
            b.last = (i == cnt - 1);
            exp_q.push_back(b);
        end
        cur_cnt = cnt; exp_addr = base; issued = 0; accepted = 0;
        last_acc_cyc = -100; done_seen = 0; stall_prev = 0;
    endtask

    // Per-cycle comparison of DUT outputs against the reference model.
    task automatic sample();
        beat_t b;
        check("ram_write_en", ram_write_en, 0);
        check("ram_reset", ram_reset, reset);
        if (cyc == 1) check("first_issue", ram_enable, cur_cnt != 0);
        if (cyc <= 2) check("early_valid", m_valid, 0);
        if (cyc == 3 && cur_cnt != 0) check("first_valid", m_valid, 1);
        if (ram_enable) begin
            check("issue_busy", busy, 1);
            check("ram_address", ram_address, exp_addr);
            exp_addr = (exp_addr + 1) % DEPTH;
            issued++;
        end
        if (stall_prev) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, prev_data);
            check("hold_last", m_last, prev_last);
        end
        if (m_valid && m_ready) begin
            accepted++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 1, 0);
            end else begin
                b = exp_q.pop_front();
                check("beat_data", m_data, b.data);
                check("beat_last", m_last, b.last);
                if (b.last) begin
                    last_acc_cyc = cyc;
                    last_word = m_data;
                end
            end
        end
        stall_prev = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        check("outstanding_le2", (issued - accepted) <= 2, 1);
        if (done) begin
            done_seen = 1;
            check("done_timing", cyc, (cur_cnt == 0) ? 2 : last_acc_cyc + 1);
            check("done_queue_empty", exp_q.size(), 0);
            check("done_busy", busy, 0);
            check("done_no_valid", m_valid, 0);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        init_model(v.base, v.cnt);
        @(posedge clock); #1;
        start = 1'b1; base_addr = AW'(v.base); count = CW'(v.cnt);
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (!done_seen && cyc < 400) begin
            m_ready = ready_fn(v.mode, cyc);
            if (v.poke && cyc == 4) begin
                start = 1'b1; base_addr = 4'd7; count = 5'd3;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            sample();
            if (!done_seen) begin
                @(posedge clock); #1;
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", done_seen, 1);
        check("all_beats", exp_q.size(), 0);
        if (v.exp_done != 0) check("done_cycle", cyc, v.exp_done);
        if (v.cnt != 0) check("last_word", last_word, v.exp_last);
        @(posedge clock); #1;
        @(negedge clock);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
    endtask

    task automatic reset_check(input string tag);
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check({tag, "_ram_reset"}, ram_reset, 1);
        @(posedge clock); #1;
        @(negedge clock);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_last"}, m_last, 0);
        check({tag, "_data"}, m_data, 0);
        check({tag, "_ram_en"}, ram_enable, 0);
        check({tag, "_ram_addr"}, ram_address, 0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check({tag, "_ram_reset_rel"}, ram_reset, 0);
    endtask

    vec_t vecs [6];
    vec_t rv;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h3e000000 + i * 32'h111;
        mem[0]  = 32'h3e96bb98;
        mem[1]  = 32'h3f800000;
        mem[6]  = 32'h40490fdb;
        mem[11] = 32'h3a51b717;
        mem[15] = 32'hbf800000;

        vecs[0] = '{base: 0,  cnt: 12, mode: 0, poke: 0, exp_done: 15, exp_last: 32'h3a51b717};
        vecs[1] = '{base: 0,  cnt: 12, mode: 2, poke: 0, exp_done: 0,  exp_last: 32'h3a51b717};
        vecs[2] = '{base: 14, cnt: 4,  mode: 0, poke: 0, exp_done: 7,  exp_last: 32'h3f800000};
        vecs[3] = '{base: 3,  cnt: 0,  mode: 0, poke: 0, exp_done: 2,  exp_last: 32'h0};
        vecs[4] = '{base: 2,  cnt: 5,  mode: 0, poke: 1, exp_done: 8,  exp_last: 32'h40490fdb};
        vecs[5] = '{base: 15, cnt: 1,  mode: 1, poke: 0, exp_done: 0,  exp_last: 32'hbf800000};

        cyc = 0;
        reset_check("reset_init");
        for (int i = 0; i < 6; i++) run_cmd(vecs[i]);
        reset_check("reset_idle");

        // Abandon a command mid-stream with the buffer full.
        init_model(0, 12);
        @(posedge clock); #1;
        start = 1'b1; base_addr = 4'd0; count = 5'd12;
        @(posedge clock); #1;
        start = 1'b0;
        cyc = 1;
        while (accepted < 5 && cyc < 100) begin
            m_ready = (accepted < 5);
            @(negedge clock);
            sample();
            @(posedge clock); #1;
            cyc++;
        end
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            sample();
            @(posedge clock); #1;
            cyc++;
        end
        check("abort_accepted", accepted, 5);
        check("abort_fifo_full", issued - accepted, 2);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_valid", m_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_ram_en", ram_enable, 0);
            @(posedge clock); #1;
        end
        rv = '{base: 5, cnt: 3, mode: 0, poke: 0, exp_done: 6, exp_last: mem[7]};
        run_cmd(rv);

        // Randomized commands, including counts beyond the RAM depth.
        for (int i = 0; i < 12; i++) begin
            rv.base = int'($urandom % DEPTH);
            rv.cnt  = int'($urandom % 21);
            rv.mode = (i % 2 == 0) ? 1 : 3;
            rv.poke = (($urandom % 3) == 0);
            rv.exp_done = 0;
            rv.exp_last = mem[(rv.base + rv.cnt + DEPTH - 1) % DEPTH];
            run_cmd(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coef_stream_reader.md
# coef_stream_reader

Read sequencer that sits directly downstream of the single-port coefficient RAM (registered read, one-cycle latency). On a start command it walks a contiguous address range, issues RAM reads, absorbs the read latency in a 2-entry output buffer, and presents the words as a valid/ready stream with a last-beat marker. It lets arithmetic consumers pull stored float32 coefficients under backpressure without losing or duplicating words.

## Interface
Parameters:
- MEM_WIDTH, 32, RAM word width (stream data width)
- MEM_DEPTH, 1024, RAM depth; AW = $clog2(MEM_DEPTH)
- CNT_W, $clog2(MEM_DEPTH)+1, width of the beat count

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock for all state
- reset  in  1  synchronous active-high reset
- start  in  1  command strobe; sampled only in IDLE
- base_addr  in  AW  first RAM address
- count  in  CNT_W  number of words to stream (0 allowed)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when a command completes
- ram_enable  out  1  to RAM enable; high only on read-issue cycles
- ram_write_en  out  1  tied 0
- ram_reset  out  1  driven equal to reset
- ram_address  out  AW  to RAM address
- ram_data_out  in  MEM_WIDTH  from RAM registered read data
- m_data  out  MEM_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- m_last  out  1  high with the final beat of a command

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches base_addr into addr register, count into remaining; count=0 -> go directly to DRAIN (no reads); else -> RUN. start while busy is ignored.
- Read issue (RUN only): issue when remaining != 0 and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready, inflight = a read was issued last cycle. Issue = ram_enable=1, ram_address=addr; at the edge: addr advances, remaining decrements, inflight set.
- Address advance: addr == MEM_DEPTH-1 wraps to 0 (explicit compare; valid for non-power-of-2 depth). count > MEM_DEPTH permitted; addresses keep wrapping.
- Capture: cycle after an issue, ram_data_out is pushed into the 2-entry FIFO at the next edge, tagged last if it was the final issue.
- RUN -> DRAIN on the edge issuing the last read.
- DRAIN -> IDLE when FIFO empty, inflight=0, and no beat pending; done pulses in the first IDLE cycle. For count=0, done pulses one cycle after the start edge.
- Stream: m_valid = FIFO non-empty; m_data/m_last = FIFO head. Once m_valid is high, m_valid, m_data, m_last hold until m_ready. Order equals address order; no loss, no duplication.
- FIFO: simultaneous push and pop permitted at any occupancy, including full (pop frees the slot same edge). Issue rule guarantees no overflow.

## Timing
- Reset (edge with reset=1): state IDLE, FIFO flushed, inflight=0; busy=0, done=0, m_valid=0, m_last=0, m_data=0, ram_enable=0, ram_address=0. Applies mid-command: the command is abandoned, no done pulse.
- Latency: start sampled at edge N -> ram_enable=1 with ram_address=base_addr during cycle after N -> data in FIFO at edge N+2 -> m_valid=1 after edge N+2.
- Throughput: with m_ready held 1, one beat per cycle after the first; a count-K command completes with done pulse after edge N+K+2.
- Backpressure: with m_ready=0, at most 2 reads outstanding/buffered; ram_enable stays 0 until a slot frees.
- done and m_last never coincide in the same cycle; done follows the edge where the m_last beat is accepted.

## Test plan
- Reset: hold reset 2 cycles mid-idle -> all outputs 0, busy=0; ram_reset follows reset.
- Full-rate read: RAM preloaded (addr0=0x3e96bb98 … addr11=0x3a51b717), base 0, count 12, m_ready=1 -> 12 consecutive beats in address order, first m_valid 2 edges after start edge, m_last on beat 12 (0x3a51b717), done one cycle later.
- Backpressure: same command, m_ready=0 for cycles 3–8 then toggling 1/0 -> m_data stable while stalled, ram_enable=0 with FIFO full, all 12 words received exactly once in order.
- Wrap: MEM_DEPTH=16, base 14, count 4 -> ram_address sequence 14,15,0,1; m_last on address 1 data.
- Edge commands: count=0 -> no ram_enable, no m_valid, done one cycle after start; start pulsed while busy -> ignored, current command unchanged.
- Reset mid-stream: reset asserted after 5 beats of a count-12 command with FIFO full -> next cycle m_valid=0, busy=0, no done; a new command then streams correctly from its base_addr.
